// File: rtl/downscale_stream_if.sv
// Stream bundle for downscale_stream: frame start, input beats,
// output beats and frame status.
interface downscale_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 1
);
  logic                             start_i;
  logic                             in_valid_i;
  logic                             in_ready_o;
  logic [LANES*DATA_WIDTH-1:0]      data_i;
  logic                             out_valid_o;
  logic                             out_ready_i;
  logic [LANES*(DATA_WIDTH+1)-1:0]  sub_result_o;
  logic                             out_last_o;
  logic [DATA_WIDTH-1:0]            max_o;
  logic                             busy_o;
  logic                             done_o;

  modport master (
    output start_i, in_valid_i, data_i, out_ready_i,
    input  in_ready_o, out_valid_o, sub_result_o,
    input  out_last_o, max_o, busy_o, done_o
  );

  modport slave (
    input  start_i, in_valid_i, data_i, out_ready_i,
    output in_ready_o, out_valid_o, sub_result_o,
    output out_last_o, max_o, busy_o, done_o
  );
endinterface

// File: rtl/downscale_stream.sv
// Buffers one frame, tracks its signed maximum, then streams
// out every element minus that maximum.
module downscale_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_DATA   = 10,
  parameter int LANES      = 1
) (
  input  logic clock_i,
  input  logic reset_i,
  downscale_stream_if.slave bus
);
  localparam int BEATS = NUM_DATA / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RW    = DATA_WIDTH + 1;
  localparam int BW    = LANES * DATA_WIDTH;

  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic signed [DATA_WIDTH-1:0] MIN_VAL =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_ptr;
  logic          done_q;

  logic signed [DATA_WIDTH-1:0] max_q;
  logic signed [DATA_WIDTH-1:0] beat_max;
  logic signed [DATA_WIDTH-1:0] lane_val;

  logic [BW-1:0]         mem [BEATS];
  logic [BW-1:0]         rd_word;
  logic [LANES*RW-1:0]   sub;

  logic start_ok;
  logic in_fire;
  logic out_fire;
  logic last_rd;

  assign start_ok = (state == IDLE) && bus.start_i;
  assign in_fire  = (state == LOAD) && bus.in_valid_i;
  assign out_fire = (state == DRAIN) && bus.out_ready_i;
  assign last_rd  = (state == DRAIN) && (rd_ptr == LAST);
  assign rd_word  = mem[rd_ptr];

  // Running max folds in every lane of the current beat.
  always_comb begin
    beat_max = max_q;
    lane_val = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_val = $signed(bus.data_i[k*DATA_WIDTH +: DATA_WIDTH]);
      if (lane_val > beat_max) beat_max = lane_val;
    end
  end

  // One extra bit makes x - max exact for any pair.
  always_comb begin
    sub = '0;
    if (state == DRAIN) begin
      for (int k = 0; k < LANES; k++) begin
        sub[k*RW +: RW] =
          {rd_word[k*DATA_WIDTH + DATA_WIDTH - 1],
           rd_word[k*DATA_WIDTH +: DATA_WIDTH]}
          - {max_q[DATA_WIDTH-1], max_q};
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start_i) state_nxt = LOAD;
      LOAD:    if (in_fire && wr_cnt == LAST) state_nxt = DRAIN;
      DRAIN:   if (out_fire && last_rd) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_cnt <= '0;
      rd_ptr <= '0;
      max_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= out_fire && last_rd;
      if (start_ok) begin
        wr_cnt <= '0;
        rd_ptr <= '0;
        max_q  <= MIN_VAL;
      end
      if (in_fire) begin
        wr_cnt <= (wr_cnt == LAST) ? '0 : wr_cnt + CW'(1);
        max_q  <= beat_max;
      end
      if (out_fire) begin
        rd_ptr <= last_rd ? '0 : rd_ptr + CW'(1);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i && in_fire) mem[wr_cnt] <= bus.data_i;
  end

  assign bus.in_ready_o   = (state == LOAD);
  assign bus.out_valid_o  = (state == DRAIN);
  assign bus.sub_result_o = sub;
  assign bus.out_last_o   = last_rd;
  assign bus.max_o        = max_q;
  assign bus.busy_o       = (state != IDLE);
  assign bus.done_o       = done_q;
endmodule

// File: tb/tb_downscale_stream.sv
// Bench for downscale_stream: fixed vectors, stalls, reset,
// start handling, two-lane packing and random frames.
module tb_downscale_stream;
  localparam int DW = 16;
  localparam int ND = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  downscale_stream_if #(.DATA_WIDTH(DW), .LANES(1)) u1();
  downscale_stream_if #(.DATA_WIDTH(DW), .LANES(2)) u2();

  downscale_stream #(
    .DATA_WIDTH(DW), .NUM_DATA(ND), .LANES(1)
  ) dut1 (
    .clock_i(clk), .reset_i(rst), .bus(u1.slave)
  );

  downscale_stream #(
    .DATA_WIDTH(DW), .NUM_DATA(ND), .LANES(2)
  ) dut2 (
    .clock_i(clk), .reset_i(rst), .bus(u2.slave)
  );

  int tests = 0;
  int fails = 0;

  typedef int frame_t [ND];
  typedef struct {
    frame_t x;
    int     mx;
    frame_t y;
  } vec_t;

  vec_t tbl [3];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model(input frame_t x, output int mx,
                                output frame_t y);
    mx = x[0];
    foreach (x[i]) if (x[i] > mx) mx = x[i];
    foreach (x[i]) y[i] = x[i] - mx;
  endfunction

  // mode 0: full rate, 1: random valid + 3-cycle drain stall,
  // 2: random valid and random ready. Ends on the done cycle.
  task automatic run1(input frame_t x, input int mx, input frame_t y,
                      input int mode, input bit poke);
    int i, j, cyc, stall;
    bit v, acc, r, hold;
    logic [DW:0] psub;
    logic plast;
    u1.start_i = 1'b1;
    @(negedge clk);
    u1.start_i = 1'b0;
    chk("load_ready", int'(u1.in_ready_o), 1);
    chk("load_busy", int'(u1.busy_o), 1);
    i = 0;
    cyc = 0;
    while (i < ND && cyc < 500) begin
      v = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      u1.in_valid_i = v;
      u1.data_i = 16'(x[i]);
      acc = v && u1.in_ready_o;
      @(negedge clk);
      cyc++;
      if (acc) i++;
    end
    u1.in_valid_i = 1'b0;
    chk("load_timeout", i, ND);
    chk("valid_after_load", int'(u1.out_valid_o), 1);
    chk("max", int'($signed(u1.max_o)), mx);
    j = 0;
    cyc = 0;
    stall = 0;
    hold = 1'b0;
    psub = '0;
    plast = 1'b0;
    while (j < ND && cyc < 500) begin
      if (mode == 1 && j == 4 && stall < 3) begin
        r = 1'b0;
        stall++;
      end else if (mode == 2) begin
        r = 1'($urandom_range(0, 1));
      end else begin
        r = 1'b1;
      end
      u1.out_ready_i = r;
      u1.start_i = poke && (j == 2);
      chk("out_valid", int'(u1.out_valid_o), 1);
      chk($sformatf("sub[%0d]", j),
          int'($signed(u1.sub_result_o)), y[j]);
      chk($sformatf("last[%0d]", j),
          int'(u1.out_last_o), int'(j == ND - 1));
      if (hold) begin
        chk("hold_sub", int'(u1.sub_result_o), int'(psub));
        chk("hold_last", int'(u1.out_last_o), int'(plast));
      end
      hold = !r;
      psub = u1.sub_result_o;
      plast = u1.out_last_o;
      @(negedge clk);
      cyc++;
      if (r) j++;
    end
    u1.start_i = 1'b0;
    u1.out_ready_i = 1'b1;
    chk("drain_timeout", j, ND);
    chk("done", int'(u1.done_o), 1);
    chk("idle_busy", int'(u1.busy_o), 0);
    chk("idle_valid", int'(u1.out_valid_o), 0);
  endtask

  initial begin
    frame_t x, y;
    int mx;
    logic [2*DW-1:0] w;

    u1.start_i = 1'b0;
    u1.in_valid_i = 1'b0;
    u1.data_i = '0;
    u1.out_ready_i = 1'b1;
    u2.start_i = 1'b0;
    u2.in_valid_i = 1'b0;
    u2.data_i = '0;
    u2.out_ready_i = 1'b1;
    rst = 1'b1;

    tbl[0].x  = '{-3, 5, -1, 2, 0, 1, -3, 6, -5, 1};
    tbl[0].mx = 6;
    tbl[0].y  = '{-9, -1, -7, -4, -6, -5, -9, 0, -11, -5};
    tbl[1].x  = '{-32768, -32768, -32768, -32768, -32768,
                  -32768, -32768, -32768, -32768, 32767};
    tbl[1].mx = 32767;
    tbl[1].y  = '{-65535, -65535, -65535, -65535, -65535,
                  -65535, -65535, -65535, -65535, 0};
    tbl[2].x  = '{4, 4, -2, 4, 0, 4, -7, 4, 1, 4};
    tbl[2].mx = 4;
    tbl[2].y  = '{0, 0, -6, 0, -4, 0, -11, 0, -3, 0};

    repeat (2) @(negedge clk);
    chk("rst_ready", int'(u1.in_ready_o), 0);
    chk("rst_valid", int'(u1.out_valid_o), 0);
    chk("rst_last", int'(u1.out_last_o), 0);
    chk("rst_busy", int'(u1.busy_o), 0);
    chk("rst_done", int'(u1.done_o), 0);
    chk("rst_max", int'(u1.max_o), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 3; t++) begin
      run1(tbl[t].x, tbl[t].mx, tbl[t].y, 0, 1'b0);
      @(negedge clk);
      chk("done_pulse", int'(u1.done_o), 0);
    end

    run1(tbl[0].x, tbl[0].mx, tbl[0].y, 1, 1'b0);
    @(negedge clk);

    // Start during DRAIN is ignored; start on done begins a frame.
    run1(tbl[0].x, tbl[0].mx, tbl[0].y, 0, 1'b1);
    run1(tbl[2].x, tbl[2].mx, tbl[2].y, 0, 1'b0);
    @(negedge clk);

    // Partial frame, then reset alongside start and a valid beat.
    u1.start_i = 1'b1;
    @(negedge clk);
    u1.start_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      u1.in_valid_i = 1'b1;
      u1.data_i = 16'(1000);
      @(negedge clk);
    end
    rst = 1'b1;
    u1.start_i = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", int'(u1.in_ready_o), 0);
    chk("mid_rst_valid", int'(u1.out_valid_o), 0);
    chk("mid_rst_busy", int'(u1.busy_o), 0);
    chk("mid_rst_max", int'(u1.max_o), 0);
    chk("mid_rst_last", int'(u1.out_last_o), 0);
    chk("mid_rst_sub", int'(u1.sub_result_o), 0);
    rst = 1'b0;
    u1.start_i = 1'b0;
    u1.in_valid_i = 1'b0;
    @(negedge clk);
    run1(tbl[0].x, tbl[0].mx, tbl[0].y, 0, 1'b0);
    @(negedge clk);

    // Two lanes: lane 0 is the even element.
    u2.start_i = 1'b1;
    @(negedge clk);
    u2.start_i = 1'b0;
    for (int b = 0; b < ND / 2; b++) begin
      w = {16'(tbl[0].x[2*b+1]), 16'(tbl[0].x[2*b])};
      u2.in_valid_i = 1'b1;
      u2.data_i = w;
      chk("l2_ready", int'(u2.in_ready_o), 1);
      @(negedge clk);
    end
    u2.in_valid_i = 1'b0;
    chk("l2_valid", int'(u2.out_valid_o), 1);
    chk("l2_max", int'($signed(u2.max_o)), 6);
    for (int b = 0; b < ND / 2; b++) begin
      chk($sformatf("l2_lane0[%0d]", b),
          int'($signed(u2.sub_result_o[16:0])), tbl[0].y[2*b]);
      chk($sformatf("l2_lane1[%0d]", b),
          int'($signed(u2.sub_result_o[33:17])), tbl[0].y[2*b+1]);
      chk("l2_last", int'(u2.out_last_o), int'(b == ND / 2 - 1));
      @(negedge clk);
    end
    chk("l2_done", int'(u2.done_o), 1);
    @(negedge clk);

    for (int f = 0; f < 16; f++) begin
      foreach (x[i]) begin
        if (f % 2 == 0) x[i] = int'($signed(16'($urandom)));
        else x[i] = int'($urandom_range(0, 6)) - 3;
      end
      model(x, mx, y);
      run1(x, mx, y, 2, 1'b0);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
